// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the board reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        WAIT_RELEASE
    } seq_state_e;

    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_RESET_HOLD_CYCLES = 65536;
    localparam int NUM_BUTTONS           = 4;
    localparam int RESET_COUNT_W         = 8;

    // A counter that must reach n-1 needs $clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// One-bit synchroniser plus stability counter for an active-low raw input;
// level is the debounced state with 1 = pressed.
module debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = ~stable_q;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_n};
        stable_d = stable_q;
        cnt_d    = '0;
        // Only an uninterrupted run of differing samples may move the stable level.
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: debounces CPU_RESET_n and BUTTON[3:0] and holds the
// Qsys system in reset for a fixed time after any reset cause clears.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES
) (
    input  logic                     clk_50mhz,
    input  logic                     rst_50mhz,
    input  logic                     cpu_reset_n_raw,
    input  logic [NUM_BUTTONS-1:0]   button_n_raw,
    output logic                     sys_reset_n,
    output logic                     sys_ready,
    output logic [NUM_BUTTONS-1:0]   button_level,
    output logic [NUM_BUTTONS-1:0]   button_press,
    output logic [RESET_COUNT_W-1:0] reset_count
);

    localparam int HOLD_W = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    logic cpu_pressed;

    seq_state_e                 state_q, state_d;
    logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
    logic [RESET_COUNT_W-1:0]   reset_count_q, reset_count_d;
    logic                       sys_reset_n_q, sys_reset_n_d;
    logic                       sys_ready_q, sys_ready_d;
    logic [NUM_BUTTONS-1:0]     button_prev_q, button_prev_d;
    logic [NUM_BUTTONS-1:0]     button_press_q, button_press_d;

    debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cpu_debounce (
        .clk  (clk_50mhz),
        .rst  (rst_50mhz),
        .raw_n(cpu_reset_n_raw),
        .level(cpu_pressed)
    );

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
        debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_button_debounce (
            .clk  (clk_50mhz),
            .rst  (rst_50mhz),
            .raw_n(button_n_raw[i]),
            .level(button_level[i])
        );
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = '0;
        reset_count_d = reset_count_q;
        case (state_q)
            HOLD: begin
                // A new press restarts the whole hold once it is released.
                if (cpu_pressed) begin
                    state_d = WAIT_RELEASE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    if (reset_count_q != '1) begin
                        reset_count_d = reset_count_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (cpu_pressed) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!cpu_pressed) begin
                    state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase
        // Outputs follow the next state so they are flops with no input-to-output path.
        sys_reset_n_d  = (state_d == RUN);
        sys_ready_d    = (state_d == RUN);
        button_prev_d  = button_level;
        button_press_d = button_level & ~button_prev_q;
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            state_q        <= HOLD;
            hold_cnt_q     <= '0;
            reset_count_q  <= '0;
            sys_reset_n_q  <= 1'b0;
            sys_ready_q    <= 1'b0;
            button_prev_q  <= '0;
            button_press_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            reset_count_q  <= reset_count_d;
            sys_reset_n_q  <= sys_reset_n_d;
            sys_ready_q    <= sys_ready_d;
            button_prev_q  <= button_prev_d;
            button_press_q <= button_press_d;
        end
    end

    assign sys_reset_n  = sys_reset_n_q;
    assign sys_ready    = sys_ready_q;
    assign button_press = button_press_q;
    assign reset_count  = reset_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short debounce and hold times.
module tb_reset_sequencer;

    localparam int SYNC_STAGES       = 2;
    localparam int DEBOUNCE_CYCLES   = 4;
    localparam int RESET_HOLD_CYCLES = 8;

    logic       clk_50mhz = 1'b0;
    logic       rst_50mhz;
    logic       cpu_reset_n_raw;
    logic [3:0] button_n_raw;
    logic       sys_reset_n;
    logic       sys_ready;
    logic [3:0] button_level;
    logic [3:0] button_press;
    logic [7:0] reset_count;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .SYNC_STAGES      (SYNC_STAGES),
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .RESET_HOLD_CYCLES(RESET_HOLD_CYCLES)
    ) dut (
        .clk_50mhz      (clk_50mhz),
        .rst_50mhz      (rst_50mhz),
        .cpu_reset_n_raw(cpu_reset_n_raw),
        .button_n_raw   (button_n_raw),
        .sys_reset_n    (sys_reset_n),
        .sys_ready      (sys_ready),
        .button_level   (button_level),
        .button_press   (button_press),
        .reset_count    (reset_count)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic cpu_n, input logic [3:0] btn_n);
        rst_50mhz       = rst;
        cpu_reset_n_raw = cpu_n;
        button_n_raw    = btn_n;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int waited;
        logic [7:0] exp_count;

        // Reset state with idle raw inputs.
        applyStimulus(1'b1, 1'b1, 4'hF);
        tick(3);
        checkOutput("rst_sys_reset_n", {7'd0, sys_reset_n}, 8'd0);
        checkOutput("rst_sys_ready", {7'd0, sys_ready}, 8'd0);
        checkOutput("rst_reset_count", reset_count, 8'd0);
        checkOutput("rst_button_level", {4'd0, button_level}, 8'd0);
        checkOutput("rst_button_press", {4'd0, button_press}, 8'd0);

        // Power-up hold: low for 8 cycles after release, then running.
        applyStimulus(1'b0, 1'b1, 4'hF);
        tick(7);
        checkOutput("hold_low_7", {7'd0, sys_reset_n}, 8'd0);
        checkOutput("hold_ready_7", {7'd0, sys_ready}, 8'd0);
        tick(1);
        checkOutput("run_sys_reset_n", {7'd0, sys_reset_n}, 8'd1);
        checkOutput("run_sys_ready", {7'd0, sys_ready}, 8'd1);
        checkOutput("run_count_1", reset_count, 8'd1);

        // CPU reset held low 20 cycles while running.
        applyStimulus(1'b0, 1'b0, 4'hF);
        tick(6);
        checkOutput("cpu_edge6_high", {7'd0, sys_reset_n}, 8'd1);
        tick(1);
        checkOutput("cpu_edge7_low", {7'd0, sys_reset_n}, 8'd0);
        checkOutput("cpu_edge7_ready", {7'd0, sys_ready}, 8'd0);
        tick(13);
        applyStimulus(1'b0, 1'b1, 4'hF);
        // Debounced release after edge 26, HOLD from edge 27, RUN at edge 35.
        tick(14);
        checkOutput("cpu_rel_low_34", {7'd0, sys_reset_n}, 8'd0);
        checkOutput("cpu_rel_count_34", reset_count, 8'd1);
        tick(1);
        checkOutput("cpu_rel_high_35", {7'd0, sys_reset_n}, 8'd1);
        checkOutput("cpu_count_2", reset_count, 8'd2);

        // A 3-cycle glitch on button 2 must be filtered out.
        applyStimulus(1'b0, 1'b1, 4'b1011);
        tick(3);
        applyStimulus(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("glitch_level", {4'd0, button_level}, 8'd0);
            checkOutput("glitch_press", {4'd0, button_press}, 8'd0);
        end

        // Button 1 held 10 cycles: level at edge 6, press pulse at edge 7 only.
        applyStimulus(1'b0, 1'b1, 4'b1101);
        tick(5);
        checkOutput("btn1_level_5", {4'd0, button_level}, 8'd0);
        tick(1);
        checkOutput("btn1_level_6", {4'd0, button_level}, 8'd2);
        checkOutput("btn1_press_6", {4'd0, button_press}, 8'd0);
        tick(1);
        checkOutput("btn1_press_7", {4'd0, button_press}, 8'd2);
        tick(1);
        checkOutput("btn1_press_8", {4'd0, button_press}, 8'd0);
        checkOutput("btn1_level_8", {4'd0, button_level}, 8'd2);
        tick(2);
        applyStimulus(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("btn1_release_press", {4'd0, button_press}, 8'd0);
        end
        checkOutput("btn1_release_level", {4'd0, button_level}, 8'd0);
        checkOutput("btn_ready_kept", {7'd0, sys_ready}, 8'd1);

        // Synchronous reset aborting HOLD at count 5.
        applyStimulus(1'b1, 1'b1, 4'hF);
        tick(2);
        checkOutput("abort_pre_count", reset_count, 8'd0);
        applyStimulus(1'b0, 1'b1, 4'hF);
        tick(5);
        applyStimulus(1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("abort_sys_reset_n", {7'd0, sys_reset_n}, 8'd0);
            checkOutput("abort_count", reset_count, 8'd0);
        end
        applyStimulus(1'b0, 1'b1, 4'hF);
        tick(7);
        checkOutput("abort_hold_low_7", {7'd0, sys_reset_n}, 8'd0);
        checkOutput("abort_hold_count_7", reset_count, 8'd0);
        tick(1);
        checkOutput("abort_hold_high_8", {7'd0, sys_reset_n}, 8'd1);
        checkOutput("abort_count_1", reset_count, 8'd1);

        // 260 CPU reset sequences; the counter must stop at 255.
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, 1'b0, 4'hF);
            tick(8);
            applyStimulus(1'b0, 1'b1, 4'hF);
            waited = 0;
            while (!sys_ready && waited < 60) begin
                tick(1);
                waited++;
            end
            checkOutput("sat_ready", {7'd0, sys_ready}, 8'd1);
            exp_count = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
            checkOutput("sat_count", reset_count, exp_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
